// File: rtl/f32_addsub_sched_if.sv
// Bundles the requester, datapath and result signals of the shared F32 add/sub scheduler.
interface f32_addsub_sched_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] a_in;
  logic [NREQ*32-1:0] b_in;
  logic [NREQ-1:0]    op_in;
  logic [NREQ-1:0]    gnt;

  logic [31:0]        dp_a;
  logic [31:0]        dp_b;
  logic               dp_op;
  logic [7:0]         dp_debug;
  logic [31:0]        dp_r;
  logic               dp_underflow;
  logic               dp_overflow;

  logic [31:0]        res;
  logic               res_uf;
  logic               res_of;
  logic [IDW-1:0]     res_id;
  logic               res_valid;
  logic               res_ready;

  // Scheduler side
  modport slave (
    input  req, a_in, b_in, op_in, dp_r, dp_underflow, dp_overflow, res_ready,
    output gnt, dp_a, dp_b, dp_op, dp_debug, res, res_uf, res_of, res_id, res_valid
  );

  // Requesters, datapath and result consumer side
  modport master (
    output req, a_in, b_in, op_in, dp_r, dp_underflow, dp_overflow, res_ready,
    input  gnt, dp_a, dp_b, dp_op, dp_debug, res, res_uf, res_of, res_id, res_valid
  );
endinterface

// File: rtl/f32_addsub_sched.sv
// Round-robin scheduler sharing one combinational F32 adder/subtractor among NREQ
// requesters. The winner's operands are registered onto the datapath, held for
// SETTLE_CYCLES, and the sampled result is returned over a valid/ready handshake.
module f32_addsub_sched #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input logic               clk,
  input logic               rst_n,
  f32_addsub_sched_if.slave bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state, state_nx;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    id;
  logic [CNTW-1:0]   cnt;

  logic              found;
  logic [IDW-1:0]    win;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic              sel_op;
  logic [NREQ-1:0]   gnt;

  logic [31:0]       dp_a;
  logic [31:0]       dp_b;
  logic              dp_op;
  logic [31:0]       res;
  logic              res_uf;
  logic              res_of;
  logic [IDW-1:0]    res_id;
  logic              res_valid;

  // Round-robin pick: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1
  always_comb begin
    found  = 1'b0;
    win    = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i] && (i >= 32'(ptr))) begin
        found  = 1'b1;
        win    = IDW'(i);
        sel_a  = bus.a_in[32*i +: 32];
        sel_b  = bus.b_in[32*i +: 32];
        sel_op = bus.op_in[i];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i]) begin
        found  = 1'b1;
        win    = IDW'(i);
        sel_a  = bus.a_in[32*i +: 32];
        sel_b  = bus.b_in[32*i +: 32];
        sel_op = bus.op_in[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and grant decode
  always_comb begin
    state_nx = state;
    gnt      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt      = NREQ'(1) << win;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nx = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at the grant edge, settle countdown, result capture and release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_op     <= 1'b0;
      res       <= '0;
      res_uf    <= 1'b0;
      res_of    <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            dp_a  <= sel_a;
            dp_b  <= sel_b;
            dp_op <= sel_op;
            id    <= win;
            cnt   <= CNTW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res       <= bus.dp_r;
            res_uf    <= bus.dp_underflow;
            res_of    <= bus.dp_overflow;
            res_id    <= id;
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            ptr       <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.dp_a      = dp_a;
  assign bus.dp_b      = dp_b;
  assign bus.dp_op     = dp_op;
  assign bus.dp_debug  = 8'h00;
  assign bus.res       = res;
  assign bus.res_uf    = res_uf;
  assign bus.res_of    = res_of;
  assign bus.res_id    = res_id;
  assign bus.res_valid = res_valid;
endmodule

// File: tb/tb_f32_addsub_sched.sv
// Scoreboard bench for f32_addsub_sched with a behavioural F32 add/sub datapath.
module tb_f32_addsub_sched;
  localparam int NREQ   = 4;
  localparam int SETTLE = 3;

  logic clk;
  logic rst_n;

  f32_addsub_sched_if #(.NREQ(NREQ)) bus ();

  f32_addsub_sched #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] r;
    logic        uf;
    logic        of;
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t            exp_res[$];
  logic [3:0]      exp_gnt[$];
  int              gnt_time[$];
  int              gnt_log[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural F32 add/sub (truncating, flush-to-zero); returns {uf, of, r}
  function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    logic        sa, sb, s, ts;
    int          ea, eb, e, te, d;
    logic [25:0] ma, mb, m, tm;
    sa = a[31];
    sb = b[31] ^ op;
    ea = 32'(a[30:23]);
    eb = 32'(b[30:23]);
    ma = (ea == 0) ? 26'd0 : {3'b001, a[22:0]};
    mb = (eb == 0) ? 26'd0 : {3'b001, b[22:0]};
    if (eb > ea || (eb == ea && mb > ma)) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    d  = ea - eb;
    mb = (d > 25) ? 26'd0 : (mb >> d);
    e  = ea;
    s  = sa;
    if (sa == sb) begin
      m = ma + mb;
      if (m[24]) begin
        m = m >> 1;
        e = e + 1;
      end
    end else begin
      m = ma - mb;
    end
    if (m == 26'd0) return 34'd0;
    while (!m[23]) begin
      m = m << 1;
      e = e - 1;
    end
    if (e >= 255) return {1'b0, 1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b1, 1'b0, s, 31'd0};
    return {1'b0, 1'b0, s, 8'(e), m[22:0]};
  endfunction

  assign {bus.dp_underflow, bus.dp_overflow, bus.dp_r} = fp_model(bus.dp_a, bus.dp_b, bus.dp_op);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] r, input logic uf, input logic of);
    exp_t e;
    bus.a_in[32*i +: 32] = a;
    bus.b_in[32*i +: 32] = b;
    bus.op_in[i]         = op;
    e.r  = r;
    e.uf = uf;
    e.of = of;
    e.id = 2'(i);
    e.a  = a;
    e.b  = b;
    exp_res.push_back(e);
    exp_gnt.push_back(4'(1 << i));
  endtask

  // Requester i drops its request just after the edge that captured its grant
  task automatic wait_gnt(input int i);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.gnt[i]) begin
        @(posedge clk);
        #1;
        bus.req[i] = 1'b0;
        return;
      end
    end
    fail_now($sformatf("gnt_wait_%0d", i));
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_res.size() == 0 && exp_gnt.size() == 0 && !bus.res_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("idle_wait");
    @(posedge clk);
    #1;
  endtask

  // Monitor: grants, operand stability, result value, latency and backpressure stability
  initial begin
    logic        prev_valid;
    logic        snap_pending;
    logic        busy;
    logic [31:0] snap_a, snap_b, hold_r;
    logic [1:0]  hold_id;
    exp_t        e;
    int          t;
    prev_valid   = 1'b0;
    snap_pending = 1'b0;
    busy         = 1'b0;
    snap_a = '0; snap_b = '0; hold_r = '0; hold_id = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid   = 1'b0;
        snap_pending = 1'b0;
        busy         = 1'b0;
        gnt_time.delete();
      end else begin
        if (snap_pending) begin
          snap_a = bus.dp_a;
          snap_b = bus.dp_b;
          if (exp_res.size() > 0) begin
            check("dp_a_captured", 64'(bus.dp_a), 64'(exp_res[0].a));
            check("dp_b_captured", 64'(bus.dp_b), 64'(exp_res[0].b));
          end
          snap_pending = 1'b0;
          busy         = 1'b1;
        end else if (busy) begin
          check("dp_a_stable", 64'(bus.dp_a), 64'(snap_a));
          check("dp_b_stable", 64'(bus.dp_b), 64'(snap_b));
        end

        if (bus.gnt != '0) begin
          if (exp_gnt.size() == 0) begin
            check("unexpected_gnt", 64'(bus.gnt), 64'd0);
          end else begin
            check("gnt", 64'(bus.gnt), 64'(exp_gnt.pop_front()));
          end
          check("gnt_while_valid", 64'(bus.res_valid), 64'd0);
          check("dp_debug", 64'(bus.dp_debug), 64'd0);
          gnt_time.push_back(cyc);
          gnt_log.push_back(cyc);
          snap_pending = 1'b1;
        end

        if (bus.res_valid && !prev_valid) begin
          if (exp_res.size() == 0) begin
            check("unexpected_res_valid", 64'(bus.res_valid), 64'd0);
          end else begin
            e = exp_res.pop_front();
            check("res",    64'(bus.res),    64'(e.r));
            check("res_uf", 64'(bus.res_uf), 64'(e.uf));
            check("res_of", 64'(bus.res_of), 64'(e.of));
            check("res_id", 64'(bus.res_id), 64'(e.id));
          end
          if (gnt_time.size() == 0) begin
            fail_now("latency_no_grant");
          end else begin
            t = gnt_time.pop_front();
            check("latency", 64'(cyc - t), 64'(SETTLE + 1));
          end
          hold_r  = bus.res;
          hold_id = bus.res_id;
        end else if (bus.res_valid && prev_valid) begin
          check("res_hold",    64'(bus.res),    64'(hold_r));
          check("res_id_hold", 64'(bus.res_id), 64'(hold_id));
        end

        if (bus.res_valid && bus.res_ready) busy = 1'b0;
        prev_valid = bus.res_valid;
      end
    end
  end

  // Stimulus
  initial begin
    bool_dummy();
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.op_in     = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",       64'(bus.gnt),       64'd0);
    check("rst_dp_a",      64'(bus.dp_a),      64'd0);
    check("rst_dp_b",      64'(bus.dp_b),      64'd0);
    check("rst_dp_op",     64'(bus.dp_op),     64'd0);
    check("rst_res",       64'(bus.res),       64'd0);
    check("rst_flags",     64'({bus.res_uf, bus.res_of}), 64'd0);
    check("rst_res_id",    64'(bus.res_id),    64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add: 1.0 + 2.0
    push_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
    bus.req[0] = 1'b1;
    wait_gnt(0);
    wait_idle();

    // Subtract on requester 2: 3.0 - 1.0
    push_op(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    bus.req[2] = 1'b1;
    wait_gnt(2);
    wait_idle();

    // Overflow: max normal + max normal
    push_op(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1);
    bus.req[1] = 1'b1;
    wait_gnt(1);
    wait_idle();

    // Underflow: 1.5*2^-126 - 1.0*2^-126 falls below the normal range
    push_op(3, 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    bus.req[3] = 1'b1;
    wait_gnt(3);
    wait_idle();

    // Fairness: all four held high, ptr is back at 0
    gnt_log.delete();
    push_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    push_op(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0);
    push_op(2, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 1'b0, 1'b0);
    push_op(3, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    push_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    bus.req = 4'b1111;
    begin : fair_wait
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (gnt_log.size() >= 5) disable fair_wait;
      end
      fail_now("fairness_wait");
    end
    @(posedge clk);
    #1;
    bus.req = '0;
    if (gnt_log.size() >= 5) begin
      for (int k = 1; k < 5; k++) check("grant_period", 64'(gnt_log[k] - gnt_log[k-1]), 64'd5);
    end
    wait_idle();

    // Backpressure: 1.0 - 1.0 = +0 held for 10 cycles, next request queued meanwhile
    bus.res_ready = 1'b0;
    push_op(1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    bus.req[1] = 1'b1;
    wait_gnt(1);
    begin : valid_wait
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.res_valid) disable valid_wait;
      end
      fail_now("valid_wait");
    end
    @(posedge clk);
    #1;
    push_op(2, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0);
    bus.req[2] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_no_gnt", 64'(bus.gnt),       64'd0);
      check("bp_valid",  64'(bus.res_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("hs_valid", 64'(bus.res_valid), 64'd1);
    check("hs_gnt",   64'(bus.gnt),       64'd0);
    @(negedge clk);
    check("post_hs_valid", 64'(bus.res_valid), 64'd0);
    check("post_hs_gnt",   64'(bus.gnt),       64'b0100);
    @(posedge clk);
    #1;
    bus.req[2] = 1'b0;
    wait_idle();

    // Reset during SETTLE with cnt=1 (ptr is 3 at this point)
    push_op(2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
    bus.req[2] = 1'b1;
    wait_gnt(2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_res.delete();
    #1;
    check("mid_rst_dp_a",      64'(bus.dp_a),      64'd0);
    check("mid_rst_dp_b",      64'(bus.dp_b),      64'd0);
    check("mid_rst_dp_op",     64'(bus.dp_op),     64'd0);
    check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_gnt",       64'(bus.gnt),       64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_res_after_rst", 64'(bus.res_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    // ptr restarted at 0, so 2 wins over 3
    push_op(2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
    push_op(3, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    bus.req = 4'b1100;
    wait_gnt(2);
    wait_gnt(3);
    wait_idle();

    // Wrap priority: after id 3, 1001 grants 0 then 3
    push_op(0, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0);
    push_op(3, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    bus.req = 4'b1001;
    wait_gnt(0);
    wait_gnt(3);
    wait_idle();

    check("exp_gnt_drained", 64'(exp_gnt.size()), 64'd0);
    check("exp_res_drained", 64'(exp_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic bool_dummy();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
